// File: rtl/sc_pkg.sv
// Shared types, LFSR tap table and bit-reversal helper for the stochastic number generator.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_sng_state_e;

    // Maximal-length Galois (right-shift) feedback masks, indexed by LFSR width.
    localparam logic [15:0] LFSR_TAPS [3:16] = '{
        16'h0006, 16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110,
        16'h0240, 16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
    };

    function automatic logic [15:0] bitrev(input logic [15:0] value, input int width);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (i < width) begin
                r[width-1-i] = value[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Galois LFSR random source; reloads SEED on load and advances one step per step pulse.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int             W    = 8,
    parameter logic [W-1:0]   SEED = W'(1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] state
);

    // Legal for W in 3..16, the range covered by the tap table.
    localparam logic [W-1:0] TAPS = W'(LFSR_TAPS[W]);

    logic [W-1:0] next_s;

    // Next-state shift with feedback from the bit falling out of the register.
    always_comb begin
        next_s = {1'b0, state[W-1:1]};
        if (state[0]) begin
            next_s = next_s ^ TAPS;
        end else begin
            next_s = {1'b0, state[W-1:1]};
        end
    end

    // State register; load takes priority over step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (step) begin
            state <= next_s;
        end else begin
            state <= state;
        end
    end

endmodule

// File: rtl/sc_sng_ctrl.sv
// Stochastic number generator front end: binary operand to bitstream plus rshift schedule.
// Define SC_SNG_VDC_EN to use a Van der Corput source instead of the LFSR comparator.
module sc_sng_ctrl
    import sc_pkg::*;
#(
    parameter int           W    = 8,
    parameter int           PMAX = 8,
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [W-1:0]                x,
    input  logic [$clog2(PMAX+1)-1:0]   prec,
    output logic                        busy,
    output logic                        z,
    output logic                        z_vld,
    output logic                        rshift,
    output logic                        done
);

    localparam int CW = PMAX + 1;
    localparam int PW = $clog2(PMAX + 1);

    sc_sng_state_e  state_r;
    logic [CW-1:0]  cnt_r;
    logic [W-1:0]   x_r;
    logic [PW-1:0]  prec_r;
    logic           busy_r;
    logic           z_vld_r;
    logic           done_r;

    logic [PW-1:0]  prec_clamp_s;
    logic [CW-1:0]  last_cnt_s;
    logic [CW-1:0]  cnt_inc_s;
    logic           pow2_s;
    logic           hit_s;

    // Clamp requested precision into 1..PMAX.
    always_comb begin
        prec_clamp_s = prec;
        if (prec == {PW{1'b0}}) begin
            prec_clamp_s = PW'(1);
        end else if (int'(prec) > PMAX) begin
            prec_clamp_s = PW'(PMAX);
        end else begin
            prec_clamp_s = prec;
        end
    end

    // Final count and power-of-two boundary detection; cnt is one bit wider than PMAX so it never wraps.
    always_comb begin
        last_cnt_s = (CW'(1) << prec_r) - CW'(1);
        cnt_inc_s  = cnt_r + CW'(1);
        pow2_s     = ((cnt_inc_s & cnt_r) == {CW{1'b0}}) && (cnt_r != {CW{1'b0}});
    end

`ifdef SC_SNG_VDC_EN
    logic [W-1:0]  cnt_low_s;
    logic [15:0]   rev_s;
    logic [W-1:0]  rnd_s;

    // Van der Corput source: bit-reversed run counter.
    always_comb begin
        cnt_low_s = W'(cnt_r);
        rev_s     = bitrev(16'(cnt_low_s), W);
        rnd_s     = W'(rev_s);
        hit_s     = (rnd_s < x_r);
    end
`else
    logic [W-1:0]  lfsr_s;
    logic          lfsr_load_s;
    logic          lfsr_step_s;

    // LFSR reloads on an accepted start and steps on every RUN cycle.
    always_comb begin
        lfsr_load_s = (state_r == IDLE) && start;
        lfsr_step_s = (state_r == RUN);
        hit_s       = (lfsr_s <= x_r);
    end

    sc_lfsr #(
        .W    (W),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load_s),
        .step  (lfsr_step_s),
        .state (lfsr_s)
    );
`endif

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            x_r     <= {W{1'b0}};
            prec_r  <= {PW{1'b0}};
            busy_r  <= 1'b0;
            z_vld_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        x_r     <= x;
                        prec_r  <= prec_clamp_s;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        z_vld_r <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                        z_vld_r <= 1'b0;
                    end
                end
                RUN: begin
                    cnt_r <= cnt_inc_s;
                    if (cnt_r == last_cnt_s) begin
                        state_r <= DONE;
                        z_vld_r <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        z_vld_r <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    z_vld_r <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    z_vld_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // z and rshift are gated by z_vld so both read 0 outside RUN.
    always_comb begin
        busy   = busy_r;
        z_vld  = z_vld_r;
        done   = done_r;
        z      = z_vld_r && hit_s;
        rshift = z_vld_r && pow2_s;
    end

endmodule

// File: tb/tb_sc_sng_ctrl.sv
// Directed self-checking bench for sc_sng_ctrl (default LFSR build, W=8, PMAX=8, SEED=1).
module tb_sc_sng_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] x;
    logic [3:0] prec;
    logic       busy;
    logic       z;
    logic       z_vld;
    logic       rshift;
    logic       done;

    int a_cnt;
    int f_cnt;

    sc_sng_ctrl #(.W(8), .PMAX(8), .SEED(8'd1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x      (x),
        .prec   (prec),
        .busy   (busy),
        .z      (z),
        .z_vld  (z_vld),
        .rshift (rshift),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one run and records the stream; cycle 0 is the first cycle after start is sampled.
    task automatic run_capture(input logic [7:0] xv, input logic [3:0] pv,
                               output int nvld, output logic [255:0] zs,
                               output logic [255:0] rs, output int done_at, output int ones);
        @(negedge clk);
        x = xv; prec = pv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nvld = 0; done_at = -1; zs = '0; rs = '0; ones = 0;
        for (int c = 0; c < 400 && done_at < 0; c++) begin
            if (z_vld) begin
                if (nvld < 256) begin
                    zs[nvld] = z;
                    rs[nvld] = rshift;
                end
                ones += int'(z);
                nvld++;
            end
            if (done) done_at = c;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        a_cnt += 5;
        if (busy !== 1'b0)   begin f_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
        if (z !== 1'b0)      begin f_cnt++; $display("FAIL reset_z got %b want 0", z); end
        if (z_vld !== 1'b0)  begin f_cnt++; $display("FAIL reset_z_vld got %b want 0", z_vld); end
        if (rshift !== 1'b0) begin f_cnt++; $display("FAIL reset_rshift got %b want 0", rshift); end
        if (done !== 1'b0)   begin f_cnt++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_zero_full;
        int n, d, o;
        logic [255:0] zs, rs, rs_exp;
        run_capture(8'd0, 4'd8, n, zs, rs, d, o);
        rs_exp = '0;
        for (int k = 1; k <= 8; k++) rs_exp[(1 << k) - 1] = 1'b1;
        a_cnt += 4;
        if (n !== 256)     begin f_cnt++; $display("FAIL x0_nvld got %0d want 256", n); end
        if (zs !== '0)     begin f_cnt++; $display("FAIL x0_zbits got %h want 0", zs); end
        if (rs !== rs_exp) begin f_cnt++; $display("FAIL x0_rshift got %h want %h", rs, rs_exp); end
        if (d !== 256)     begin f_cnt++; $display("FAIL x0_done_at got %0d want 256", d); end
    endtask

    task automatic test_prec_clamp;
        int n, d, o;
        logic [255:0] zs, rs;
        run_capture(8'd255, 4'd0, n, zs, rs, d, o);
        a_cnt += 4;
        if (n !== 2)             begin f_cnt++; $display("FAIL p0_nvld got %0d want 2", n); end
        if (rs[1:0] !== 2'b10)   begin f_cnt++; $display("FAIL p0_rshift got %b want 10", rs[1:0]); end
        if (d !== 2)             begin f_cnt++; $display("FAIL p0_done_at got %0d want 2", d); end
        if (zs[1:0] !== 2'b11)   begin f_cnt++; $display("FAIL p0_zbits got %b want 11", zs[1:0]); end
        run_capture(8'd255, 4'd12, n, zs, rs, d, o);
        a_cnt += 2;
        if (n !== 256) begin f_cnt++; $display("FAIL p12_nvld got %0d want 256", n); end
        if (o !== 256) begin f_cnt++; $display("FAIL p12_ones got %0d want 256", o); end
    endtask

    task automatic test_lfsr_stream;
        int n, d, o;
        logic [255:0] zs, rs;
        // Sequence from SEED 1, mask B8: 01 B8 5C 2E 17 B3 E1 C8 compared against 0x80.
        run_capture(8'd128, 4'd3, n, zs, rs, d, o);
        a_cnt += 3;
        if (zs[7:0] !== 8'h1D)  begin f_cnt++; $display("FAIL lfsr_x128_bits got %h want 1d", zs[7:0]); end
        if (rs[7:0] !== 8'h8A)  begin f_cnt++; $display("FAIL lfsr_p3_rshift got %h want 8a", rs[7:0]); end
        if (o !== 4)            begin f_cnt++; $display("FAIL lfsr_x128_ones got %0d want 4", o); end
        run_capture(8'd255, 4'd4, n, zs, rs, d, o);
        a_cnt += 2;
        if (o !== 16)  begin f_cnt++; $display("FAIL lfsr_x255_ones got %0d want 16", o); end
        if (d !== 16)  begin f_cnt++; $display("FAIL lfsr_p4_done_at got %0d want 16", d); end
    endtask

    task automatic test_back_to_back;
        int n, d, o, nv;
        logic [255:0] zs, rs;
        logic [7:0] first;
        bit seen_done;
        @(negedge clk);
        x = 8'd128; prec = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0; first = '0; seen_done = 0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (z_vld && nv < 8) begin first[nv] = z; nv++; end
            if (c == 2) begin start = 1'b1; x = 8'd0; end
            if (c == 3) start = 1'b0;
            if (done) begin seen_done = 1; start = 1'b1; x = 8'd0; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        a_cnt += 4;
        if (!seen_done)     begin f_cnt++; $display("FAIL b2b_done_timeout got 0 want 1"); end
        if (nv !== 8)       begin f_cnt++; $display("FAIL b2b_nvld got %0d want 8", nv); end
        if (first !== 8'h1D) begin f_cnt++; $display("FAIL b2b_bits got %h want 1d", first); end
        if (busy !== 1'b0)  begin f_cnt++; $display("FAIL b2b_done_start_lost busy %b want 0", busy); end
        run_capture(8'd128, 4'd3, n, zs, rs, d, o);
        a_cnt += 2;
        if (zs[7:0] !== first) begin f_cnt++; $display("FAIL b2b_restart_bits got %h want %h", zs[7:0], first); end
        if (d !== 8)           begin f_cnt++; $display("FAIL b2b_restart_done got %0d want 8", d); end
    endtask

    task automatic test_reset_midrun;
        int n, d, o, nv;
        logic [255:0] zs, rs;
        bit hit;
        @(negedge clk);
        x = 8'd128; prec = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0; hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (z_vld) begin
                if (nv == 37) hit = 1;
                else begin nv++; @(posedge clk); #1; end
            end else begin
                @(posedge clk); #1;
            end
        end
        rst_n = 1'b0;
        #1;
        a_cnt += 5;
        if (!hit)            begin f_cnt++; $display("FAIL mid_reach_cnt37 got 0 want 1"); end
        if (busy !== 1'b0)   begin f_cnt++; $display("FAIL mid_busy got %b want 0", busy); end
        if (z_vld !== 1'b0)  begin f_cnt++; $display("FAIL mid_z_vld got %b want 0", z_vld); end
        if (z !== 1'b0 || rshift !== 1'b0) begin f_cnt++; $display("FAIL mid_z_rshift got %b%b want 00", z, rshift); end
        if (done !== 1'b0)   begin f_cnt++; $display("FAIL mid_done got %b want 0", done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_cnt += 1;
        if (done !== 1'b0 || busy !== 1'b0) begin f_cnt++; $display("FAIL mid_after_release got done %b busy %b want 0 0", done, busy); end
        run_capture(8'd0, 4'd8, n, zs, rs, d, o);
        a_cnt += 2;
        if (n !== 256) begin f_cnt++; $display("FAIL mid_rerun_nvld got %0d want 256", n); end
        if (d !== 256) begin f_cnt++; $display("FAIL mid_rerun_done got %0d want 256", d); end
    endtask

    initial begin
        a_cnt = 0; f_cnt = 0;
        rst_n = 1'b0; start = 1'b0; x = 8'd0; prec = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_zero_full;
        test_prec_clamp;
        test_lfsr_stream;
        test_back_to_back;
        test_reset_midrun;
        $display("End of test - %0d assertions evaluated, %0d failures", a_cnt, f_cnt);
        $finish;
    end

endmodule

// File: doc/sc_sng_ctrl.md
Name: sc_sng_ctrl

Overview:
- Upstream stage of the variable-shift binary counter.
- Converts a W-bit binary operand into a stochastic bitstream `z` using either a maximal-length LFSR comparator or a Van der Corput sequence.
- Schedules the `rshift` pulses so that, after 2^m bits, the downstream accumulator holds the k-weighted running mean.
- Supports progressive-precision runs of 2^prec bits, so a run can be terminated early at any lower precision.

Parameters:
- W, 8, operand width and random-source width.
- PMAX, 8, maximum precision; the stream length is at most 2^PMAX. Legal range 1..W.
- SEED, 1, LFSR reload value. Must be nonzero.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  starts a run; sampled only in IDLE.
- x  in  W  operand, captured on start.
- prec  in  $clog2(PMAX+1)  target precision, captured on start. Values 0 and >PMAX are clamped to 1 and PMAX.
- busy  out  1  high in RUN and DONE.
- z  out  1  stochastic bit; valid when z_vld is high.
- z_vld  out  1  high in every RUN cycle.
- rshift  out  1  halve pulse, aligned with the z bit it accompanies.
- done  out  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset (asynchronous): state=IDLE; busy, z, z_vld, rshift, done = 0; cnt=0; lfsr=SEED; x and prec registers cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1. On that edge: capture x and the clamped prec, set cnt=0, reload lfsr=SEED.
  - RUN -> DONE on the edge that ends the cycle with cnt = 2^prec - 1.
  - DONE -> IDLE unconditionally after one cycle.
- start is ignored outside IDLE. A start asserted in the DONE cycle is lost.
- Latency: the first z_vld occurs in the cycle after start is sampled. Exactly 2^prec consecutive z_vld cycles follow, with no gaps.
- Each RUN cycle: z is combinational from the registered cnt/lfsr and the captured x. Then cnt increments and lfsr steps (Galois form, taps taken from the package).
- LFSR comparator: z = (lfsr <= x_reg).
  - lfsr ranges over 1..2^W-1, so x=0 always gives z=0.
  - Over one full period of 2^W-1 bits, exactly x ones are produced.
- rshift = z_vld && (cnt+1 is a power of two) && (cnt+1 >= 2). It fires at cnt = 1, 3, 7, ..., 2^prec-1; the last pulse coincides with the final bit.
- Width rules:
  - cnt is PMAX+1 bits and never wraps within a run.
  - The power-of-two test is ((cnt+1) & cnt) == 0, evaluated at PMAX+1 bits.
- prec=1 (after clamp): two bits; a single rshift on the second bit; done two cycles after the first z_vld.
- Reset mid-run: immediate return to IDLE with all outputs 0. No done pulse is issued.

Optional Feature:
- Macro SC_SNG_VDC_EN.
- Defined: the LFSR is replaced by a Van der Corput source, rnd = bit-reverse of cnt[W-1:0], with z = (rnd < x_reg).
  - Any prefix of 2^m bits contains exactly floor(x·2^m / 2^W) or that value +1 ones.
  - A full run with prec=W yields exactly x ones.
  - SEED is unused.
- Undefined: LFSR source as described in Behaviour.
- Handshake and rshift timing are identical in both builds.

Decomposition:
- Package sc_pkg holds:
  - the state enum sc_sng_state_e (IDLE, RUN, DONE);
  - a localparam tap-mask table for maximal-length Galois LFSRs, widths 3..16;
  - a function bitrev(value, width).
- Sub-module sc_lfsr: parameters W and SEED; ports clk, rst_n, load, step, state[W-1:0]. It is instantiated only when SC_SNG_VDC_EN is undefined.

Test Plan:
- Run with W=8, LFSR build, x=0, prec=8 -> 256 z_vld cycles, all z=0; rshift at cnt 1, 3, 7, 15, 31, 63, 127, 255; done one cycle after the last bit.
- Run with VDC build, x=128, prec=8 -> z alternates 1,0,1,0,...; exactly 128 ones.
- Run with VDC build, x=96, prec=3 -> 8 bits containing 3 ones; hooked to vsbc with k_init=8'hFF, the final Bz equals the expected truncated mean.
- Run with prec=0 -> clamped to 1: two z_vld cycles, a single rshift on the second, then done.
- Assert start in RUN and in DONE -> both ignored. Issue a new start in IDLE two cycles after done -> the run restarts with x recaptured and lfsr reloaded to SEED; the bitstream is identical to the first run when x is identical.
- Deassert rst_n at cnt=37 -> in the same cycle, outputs go to 0 and state to IDLE; no done pulse; a subsequent start produces a full-length run.
